// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions.
//   bstuff_state_t : bit stuffer control states
//   USB_STUFF_LEN  : run of consecutive 1s after which a 0 is stuffed
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    STUFF
  } bstuff_state_t;

  localparam int unsigned USB_STUFF_LEN = 6;

endpackage

// File: rtl/bit_stuff_fsm.sv
// Control FSM for the bit stuffer: state register, next-state logic and
// the per-cycle datapath controls.
//   clock, reset_n : clock and async active-low reset
//   in_valid_i     : upstream bit valid
//   stuff_hit_i    : accepting the current bit completes a run of STUFF_LEN 1s
//   bs_ready_o     : upstream bit is consumed this cycle if in_valid_i (state only)
//   accept_o       : bit consumed this cycle
//   new_pkt_o      : consumed bit is the first of a packet
//   stuff_o        : stuffed 0 emitted this cycle
//   done_o         : packet ends this cycle
module bit_stuff_fsm
  import usb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid_i,
  input  logic stuff_hit_i,
  output logic bs_ready_o,
  output logic accept_o,
  output logic new_pkt_o,
  output logic stuff_o,
  output logic done_o
);

  bstuff_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, PASS: begin
        if (in_valid_i) begin
          state_d = stuff_hit_i ? STUFF : PASS;
        end else begin
          state_d = IDLE;
        end
      end
      // The stuffed 0 always goes out, even if in_valid dropped meanwhile.
      STUFF:   state_d = PASS;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bs_ready_o = (state_q != STUFF);
  assign accept_o   = in_valid_i && bs_ready_o;
  assign new_pkt_o  = in_valid_i && (state_q == IDLE);
  assign stuff_o    = (state_q == STUFF);
  assign done_o     = !in_valid_i && (state_q == PASS);

endmodule

// File: rtl/bit_stuff_encode.sv
// USB transmit bit stuffer. Passes packet bits with one cycle of latency and
// inserts a 0 after STUFF_LEN consecutive output 1s, stalling upstream for
// that cycle.
//   clock, reset_n : clock and async active-low reset
//   in_bit         : serial bit from the CRC encoder
//   in_valid       : in_bit valid, high contiguously for one packet
//   bs_ready       : in_bit is consumed this cycle when in_valid is high
//   out_bit        : serial bit to the NRZI encoder
//   out_valid      : out_bit valid
//   pkt_done       : one-cycle pulse after the last bit of a packet
//   stuffed_cnt    : stuffed bits in the current/last packet (saturating)
module bit_stuff_encode
  import usb_pkg::*;
#(
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             bs_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             pkt_done,
  output logic [CNT_W-1:0] stuffed_cnt
);

  localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);

  logic             accept, new_pkt, stuff, done, stuff_hit;
  logic [OnesW-1:0] ones_cnt_q, ones_cnt_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             pkt_done_q, pkt_done_d;
  logic [CNT_W-1:0] stuffed_cnt_q, stuffed_cnt_d;

  // Outside STUFF the run is always below STUFF_LEN, so one more 1 either
  // completes it or it does not.
  assign stuff_hit = in_bit && (ones_cnt_q == OnesW'(STUFF_LEN - 1));

  bit_stuff_fsm u_fsm (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid_i  (in_valid),
    .stuff_hit_i (stuff_hit),
    .bs_ready_o  (bs_ready),
    .accept_o    (accept),
    .new_pkt_o   (new_pkt),
    .stuff_o     (stuff),
    .done_o      (done)
  );

  always_comb begin
    out_bit_d     = out_bit_q;
    out_valid_d   = 1'b0;
    pkt_done_d    = 1'b0;
    ones_cnt_d    = ones_cnt_q;
    stuffed_cnt_d = stuffed_cnt_q;
    if (accept) begin
      out_bit_d   = in_bit;
      out_valid_d = 1'b1;
      ones_cnt_d  = in_bit ? ones_cnt_q + OnesW'(1) : '0;
      if (new_pkt) begin
        stuffed_cnt_d = '0;
      end
    end else if (stuff) begin
      out_bit_d   = 1'b0;
      out_valid_d = 1'b1;
      ones_cnt_d  = '0;
      if (stuffed_cnt_q != '1) begin
        stuffed_cnt_d = stuffed_cnt_q + CNT_W'(1);
      end
    end else if (done) begin
      pkt_done_d = 1'b1;
      ones_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ones_cnt_q    <= '0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      pkt_done_q    <= 1'b0;
      stuffed_cnt_q <= '0;
    end else begin
      ones_cnt_q    <= ones_cnt_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      pkt_done_q    <= pkt_done_d;
      stuffed_cnt_q <= stuffed_cnt_d;
    end
  end

  assign out_bit     = out_bit_q;
  assign out_valid   = out_valid_q;
  assign pkt_done    = pkt_done_q;
  assign stuffed_cnt = stuffed_cnt_q;

endmodule

// File: tb/tb_bit_stuff_encode.sv
// Testbench for bit_stuff_encode. Two instances (CNT_W=8 and CNT_W=4) share
// the same stimulus; the expected stream comes from a queue-based stuffing
// model or from hand-written golden sequences.
module tb_bit_stuff_encode;

  localparam int unsigned StuffLen = 6;

  logic       clock;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       bs_ready8, out_bit8, out_valid8, pkt_done8;
  logic [7:0] stuffed_cnt8;
  logic       bs_ready4, out_bit4, out_valid4, pkt_done4;
  logic [3:0] stuffed_cnt4;

  int n_checks = 0;
  int n_fails  = 0;

  bit in_q[$];
  bit gold_q[$];
  bit exp_q[$];
  int exp_pos[$];

  bit_stuff_encode #(.STUFF_LEN(StuffLen), .CNT_W(8)) u_dut8 (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .bs_ready    (bs_ready8),
    .out_bit     (out_bit8),
    .out_valid   (out_valid8),
    .pkt_done    (pkt_done8),
    .stuffed_cnt (stuffed_cnt8)
  );

  bit_stuff_encode #(.STUFF_LEN(StuffLen), .CNT_W(4)) u_dut4 (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .bs_ready    (bs_ready4),
    .out_bit     (out_bit4),
    .out_valid   (out_valid4),
    .pkt_done    (pkt_done4),
    .stuffed_cnt (stuffed_cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  // Stuff the input stream: a 0 follows every run of StuffLen output 1s.
  // exp_pos holds the output index of each stuffed 0, which is also the
  // stall cycle counted from the cycle of the first accept.
  task automatic build_model();
    int run = 0;
    exp_q.delete();
    exp_pos.delete();
    foreach (in_q[i]) begin
      exp_q.push_back(in_q[i]);
      run = in_q[i] ? run + 1 : 0;
      if (run == StuffLen) begin
        exp_pos.push_back(exp_q.size());
        exp_q.push_back(1'b0);
        run = 0;
      end
    end
    if (gold_q.size() != 0) exp_q = gold_q;
  endtask

  task automatic fill_ones(input int n);
    in_q.delete();
    gold_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(1'b1);
  endtask

  // Drive one packet; abort_stall > 0 pulses reset during that stall cycle.
  task automatic run_packet(input string tag, input int abort_stall);
    bit got8[$];
    bit got4[$];
    int stalls[$];
    int idx = 0, cyc = 0, last_out = -1, done_at = -1, done_cnt = 0;
    int bad = 0, n_stuff, limit;
    bit finished = 0;
    build_model();
    n_stuff = exp_pos.size();
    limit = 2 * in_q.size() + 20;
    while (!finished) begin
      @(negedge clock);
      if (cyc > 0) begin
        if (out_valid8) begin
          got8.push_back(out_bit8);
          last_out = cyc - 1;
        end
        if (out_valid4) got4.push_back(out_bit4);
        if (pkt_done8) begin
          done_cnt++;
          done_at = cyc - 1;
        end
      end
      if (done_cnt > 0) begin
        finished = 1;
      end else if (cyc >= limit) begin
        check_val({tag, " timeout"}, done_cnt, 1);
        in_valid = 1'b0;
        return;
      end else begin
        if (idx < in_q.size()) begin
          in_valid = 1'b1;
          in_bit   = in_q[idx];
        end else begin
          in_valid = 1'b0;
          in_bit   = 1'($urandom_range(0, 1));
        end
        if (!bs_ready8) begin
          stalls.push_back(cyc);
          if (stalls.size() == abort_stall) begin
            check_val({tag, " cnt_before_rst"}, stuffed_cnt8, abort_stall - 1);
            #1 reset_n = 1'b0;
            #1;
            check_val({tag, " rst_out_valid"}, out_valid8 | out_valid4, 0);
            check_val({tag, " rst_bs_ready"}, bs_ready8 & bs_ready4, 1);
            check_val({tag, " rst_cnt"}, stuffed_cnt8 | 8'(stuffed_cnt4), 0);
            check_val({tag, " rst_pkt_done"}, pkt_done8 | pkt_done4, 0);
            in_valid = 1'b0;
            #1 reset_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
              @(negedge clock);
              if (pkt_done8 || pkt_done4 || out_valid8) bad++;
            end
            check_val({tag, " no_done_after_rst"}, bad, 0);
            return;
          end
        end
        if (in_valid && bs_ready8) idx++;
        cyc++;
      end
    end
    in_valid = 1'b0;

    check_val({tag, " len8"}, got8.size(), exp_q.size());
    check_val({tag, " len4"}, got4.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i >= got8.size() || got8[i] != exp_q[i]) bad++;
      if (i >= got4.size() || got4[i] != exp_q[i]) bad++;
    end
    check_val({tag, " bit_errors"}, bad, 0);
    check_val({tag, " stalls"}, stalls.size(), n_stuff);
    bad = 0;
    foreach (stalls[i]) begin
      if (i >= n_stuff || stalls[i] != exp_pos[i]) bad++;
    end
    check_val({tag, " stall_pos"}, bad, 0);
    check_val({tag, " done_timing"}, done_at, last_out + 1);
    check_val({tag, " cnt8"}, stuffed_cnt8, sat(n_stuff, 8));
    check_val({tag, " cnt4"}, stuffed_cnt4, sat(n_stuff, 4));
    check_val({tag, " ready_after"}, bs_ready8, 1);
    @(negedge clock);
    check_val({tag, " done_pulse"}, pkt_done8, 0);
    check_val({tag, " idle_valid"}, out_valid8, 0);
    check_val({tag, " cnt_hold"}, stuffed_cnt8, sat(n_stuff, 8));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    #12;
    check_val("reset out_valid", out_valid8, 0);
    check_val("reset out_bit", out_bit8, 0);
    check_val("reset pkt_done", pkt_done8, 0);
    check_val("reset stuffed_cnt", stuffed_cnt8, 0);
    check_val("reset bs_ready", bs_ready8, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    fill_ones(8);
    gold_q = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
    run_packet("ones8", 0);

    fill_ones(12);
    gold_q = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
    run_packet("ones12", 0);

    in_q   = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    gold_q = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    run_packet("no_run6", 0);

    // Token: PID 8'hE1 LSB-first, then 11 ones of addr/endp.
    in_q = '{1, 0, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 11; i++) in_q.push_back(1'b1);
    gold_q = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    run_packet("token", 0);

    fill_ones(13);
    run_packet("rst_mid_stuff", 2);

    in_q   = '{0, 0, 0, 0, 0, 0};
    gold_q = '{0, 0, 0, 0, 0, 0};
    run_packet("zeros", 0);

    fill_ones(300);
    run_packet("ones300", 0);

    for (int p = 0; p < 12; p++) begin
      int len = $urandom_range(1, 40);
      in_q.delete();
      gold_q.delete();
      for (int i = 0; i < len; i++) in_q.push_back($urandom_range(0, 3) != 0);
      run_packet($sformatf("rand%0d", p), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
